mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_select.sv | 47 ++++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Bus FSM: IDLE arbitrates, ACCESS drives the memory, DONE pulses the ack.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Which requester owns the current access.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Priority decision between fetch and data requesters, with the anti-starvation
// streak counter that forces a fetch grant after MAX_STREAK data grants.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   idle_i,
    input  logic   if_req_i,
    input  logic   d_req_i,
    output logic   grant_o,
    output owner_t owner_o
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0] streak_q;
    logic [3:0] streak_d;

    // Data wins by default; a waiting fetch wins once the streak limit is hit.
    always_comb begin
        grant_o  = idle_i && (if_req_i || d_req_i);
        owner_o  = (if_req_i && (!d_req_i || streak_q == STREAK_MAX)) ? OWN_IF : OWN_D;
        streak_d = streak_q;
        if (grant_o) begin
            if (owner_o == OWN_IF) begin
                streak_d = '0;
            end else if (if_req_i) begin
                streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
            end else begin
                streak_d = '0;
            end
        end
    end

    // Streak register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter for a single-port word memory with a
// fixed access time. One access at a time: IDLE -> ACCESS x WAIT_CYCLES -> DONE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2,
    parameter int MAX_STREAK  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_data,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              mem_ce,
    output logic              mem_oe,
    output logic              mem_we
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state_q;
    logic [3:0]        wait_q;
    owner_t            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              ce_q;
    logic              oe_q;
    logic              we_q;
    logic              if_ack_q;
    logic              d_ack_q;

    logic              grant;
    owner_t            grant_owner;
    logic              unused_addr_bits;

    // Byte-lane bits and bits above the memory's reach are intentionally dropped.
    assign unused_addr_bits = ^{if_addr, d_addr};

    mem_arb_select #(
        .MAX_STREAK (MAX_STREAK)
    ) u_sel (
        .clk      (clk),
        .rst      (rst),
        .idle_i   (state_q == IDLE),
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .grant_o  (grant),
        .owner_o  (grant_owner)
    );

    // Bus FSM with registered memory strobes, latched request and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            owner_q  <= OWN_IF;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ce_q     <= 1'b0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= ACCESS;
                        wait_q  <= '0;
                        owner_q <= grant_owner;
                        ce_q    <= 1'b1;
                        if (grant_owner == OWN_IF) begin
                            addr_q <= if_addr[ADDR_W+1:2];
                            oe_q   <= 1'b1;
                            we_q   <= 1'b0;
                        end else begin
                            addr_q  <= d_addr[ADDR_W+1:2];
                            wdata_q <= d_wdata;
                            oe_q    <= !d_we;
                            we_q    <= d_we;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q  <= DONE;
                        ce_q     <= 1'b0;
                        oe_q     <= 1'b0;
                        we_q     <= 1'b0;
                        if_ack_q <= (owner_q == OWN_IF);
                        d_ack_q  <= (owner_q == OWN_D);
                        if (oe_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_ce    = ce_q;
    assign mem_oe    = oe_q;
    assign mem_we    = we_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_data   = rdata_q;
    assign d_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected accesses are queued when requests
// are issued and compared against what the memory bus and acks show.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 20;
    localparam int W  = 2;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_ack;
    logic [31:0]   if_addr, if_data;
    logic          d_req, d_we, d_ack;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_ce, mem_oe, mem_we;

    typedef struct {
        owner_t        own;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   ce_cnt = 0;
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_we;

    mem_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(W), .MAX_STREAK(MS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    // Memory model: one fixed word at address 4, a recognisable pattern elsewhere.
    assign mem_rdata = (mem_addr == 20'h4) ? 32'h24210001 : {12'hABC, mem_addr};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic push(input owner_t own, input logic we, input logic [AW-1:0] addr,
                        input logic [31:0] data);
        exp_t e;
        e.own = own; e.we = we; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(if_ack || d_ack) && n < budget);
        check("ack_seen", 32'(if_ack | d_ack), 32'd1);
    endtask

    // Bus monitor: tracks each access and retires a scoreboard entry on every ack.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            ce_cnt = 0;
        end else begin
            if (mem_ce) begin
                if (ce_cnt == 0) begin
                    acc_addr  = mem_addr;
                    acc_we    = mem_we;
                    acc_wdata = mem_wdata;
                end
                ce_cnt++;
                check("oe_xor_we", 32'(mem_oe ^ mem_we), 32'd1);
            end else begin
                check("strobes_off", 32'(mem_oe | mem_we), 32'd0);
            end
            if (if_ack || d_ack) begin
                check("ack_excl", 32'(if_ack & d_ack), 32'd0);
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("owner", 32'(d_ack ? OWN_D : OWN_IF), 32'(e.own));
                    check("addr", 32'(acc_addr), 32'(e.addr));
                    check("we", 32'(acc_we), 32'(e.we));
                    check("access_len", ce_cnt, W);
                    if (e.we) check("wdata", acc_wdata, e.data);
                    else      check("rdata", d_ack ? d_rdata : if_data, e.data);
                end
                ce_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, k, m;
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ce", 32'(mem_ce), 0);
        check("rst_oe", 32'(mem_oe), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_if_ack", 32'(if_ack), 0);
        check("rst_d_ack", 32'(d_ack), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_if_data", if_data, 0);
        check("rst_d_rdata", d_rdata, 0);
        rst = 1'b1;
        @(negedge clk);

        // Fetch only
        push(OWN_IF, 1'b0, 20'h4, 32'h24210001);
        if_addr = 32'h10; if_req = 1'b1;
        wait_ack(20, n);
        check("if_latency", n, W + 1);
        check("if_only_no_dack", 32'(d_ack), 0);
        if_req = 1'b0;
        @(negedge clk);

        // Write
        push(OWN_D, 1'b1, 20'h40, 32'hDEADBEEF);
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
        wait_ack(20, n);
        check("wr_latency", n, W + 1);
        check("wr_no_ifack", 32'(if_ack), 0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);

        // Misaligned read
        push(OWN_D, 1'b0, 20'h40, {12'hABC, 20'h40});
        d_addr = 32'h103; d_req = 1'b1;
        wait_ack(20, n);
        d_req = 1'b0;
        @(negedge clk);

        // Both held: D,D,D,D,IF repeated
        k = 0; m = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin
                push(OWN_IF, 1'b0, 20'(20'h400 + k), {12'hABC, 20'(20'h400 + k)});
                k++;
            end else begin
                push(OWN_D, 1'b0, 20'(20'h200 + m), {12'hABC, 20'(20'h200 + m)});
                m++;
            end
        end
        k = 0; m = 0;
        if_addr = 32'h1000; d_addr = 32'h800; if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_ack(20, n);
            check("both_period", n, (i == 0) ? W + 1 : W + 2);
            if (if_ack) begin
                check("streak_clr", 32'(dut.u_sel.streak_q), 0);
                k++;
                if_addr = 32'h1000 + 32'(4 * k);
            end
            if (d_ack) begin
                m++;
                d_addr = 32'h800 + 32'(4 * m);
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // Data request dropped one cycle after grant, fetch pending
        push(OWN_D, 1'b0, 20'h300, {12'hABC, 20'h300});
        push(OWN_IF, 1'b0, 20'h500, {12'hABC, 20'h500});
        d_addr = 32'hC00; if_addr = 32'h1400; d_req = 1'b1; if_req = 1'b1;
        @(negedge clk);
        d_req = 1'b0;
        wait_ack(20, n);
        check("drop_dack", 32'(d_ack), 1);
        check("drop_latency", n + 1, W + 1);
        wait_ack(20, n);
        check("drop_if_next", n, W + 2);
        if_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write
        d_we = 1'b1; d_addr = 32'h140; d_wdata = 32'h12345678; d_req = 1'b1;
        @(negedge clk);
        check("mw_we_on", 32'(mem_we), 1);
        rst = 1'b0;
        @(negedge clk);
        check("mw_we_cut", 32'(mem_we), 0);
        check("mw_ce_cut", 32'(mem_ce), 0);
        check("mw_state", 32'(dut.state_q), 32'(IDLE));
        d_req = 1'b0; d_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mw_no_ack", 32'(if_ack | d_ack), 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        push(OWN_D, 1'b1, 20'h50, 32'hCAFEF00D);
        d_we = 1'b1; d_addr = 32'h140; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
        wait_ack(20, n);
        check("post_rst_latency", n, W + 1);
        d_req = 1'b0; d_we = 1'b0;
        repeat (2) @(negedge clk);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
